icache_refill_engine: RTL

Lower-level end of the L1 instruction-cache miss interface. Takes the fetch stage's miss request and block-aligns the address. Issues one read request to the memory side, collects the block as fixed-width beats, then returns it as a single-cycle cache write (enable, address, block). Sits between the fetch stage's L1 instruction cache and the L2/memory port.

---
 rtl/fabscalar_mem_pkg.sv | 29 ++
 rtl/icache_line_assembler.sv | 54 +++++
 rtl/icache_refill_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fabscalar_mem_pkg.sv
// Purpose: shared refill-engine types and default widths for the L1I miss path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Config macro: ICACHE_PREFETCH_EN adds the next-line prefetch states to the enum.
package fabscalar_mem_pkg;

    localparam int SIZE_PC     = 32;
    localparam int CACHE_WIDTH = 256;

    localparam int DEF_ADDR_W  = SIZE_PC;
    localparam int DEF_BLOCK_W = CACHE_WIDTH;
    localparam int DEF_BEAT_W  = 64;

    typedef enum logic [3:0] {
        RF_IDLE,
        RF_REQ,
        RF_FILL,
        RF_DRAIN,
        RF_WRITE,
        RF_COOL
`ifdef ICACHE_PREFETCH_EN
        ,
        RF_PF_REQ,
        RF_PF_FILL,
        RF_PF_HIT
`endif
    } refillState_t;

endpackage

// File: rtl/icache_line_assembler.sv
// Purpose: collects BEATS fixed-width beats into one cache block (beat k -> bits [k*BEAT_W +: BEAT_W]).
// Latency: 0 cycles; 'assembled' already contains the beat presented this cycle.
// Backpressure: none; every beatValid cycle is consumed.
// Ports: clk/reset (sync, active-high); clear zeroes the beat counter; beatValid/beatData
//        deliver one beat; lastBeat flags the final beat of a block; assembled is the
//        block register with the current beat merged in.
// BLOCK_W/BEAT_W must be >= 2 and a power of two.
module icache_line_assembler #(
    parameter int BLOCK_W = 256,
    parameter int BEAT_W  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               beatValid,
    input  logic [BEAT_W-1:0]  beatData,
    output logic               lastBeat,
    output logic [BLOCK_W-1:0] assembled
);

    localparam int BEATS = BLOCK_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]   beatCnt;
    logic [BLOCK_W-1:0] blockReg;

    always_comb begin
        assembled = blockReg;
        if (beatValid) begin
            assembled[int'(beatCnt) * BEAT_W +: BEAT_W] = beatData;
        end
    end

    assign lastBeat = beatValid && (beatCnt == CNT_W'(BEATS - 1));

    // The counter wraps to zero after the last beat, so a completed or fully
    // drained block leaves the assembler ready for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            beatCnt  <= '0;
            blockReg <= '0;
        end else begin
            if (clear) begin
                beatCnt <= '0;
            end else if (beatValid) begin
                beatCnt <= beatCnt + 1'b1;
            end
            if (beatValid) begin
                blockReg <= assembled;
            end
        end
    end

endmodule

// File: rtl/icache_refill_engine.sv
// Purpose: L1I miss refill - align miss address, issue one memory read, gather beats, emit one cache write.
// Latency: miss cycle 0, ready cycle 1, beats cycles 2..BEATS+1 -> wrEnable_o in cycle BEATS+2.
// Backpressure: memReqValid_o/memReqAddr_o held until memReqReady_i; response beats cannot be stalled.
// Ports: miss_i/missAddr_i/flush_i from fetch; memReq*/memResp* to L2/memory;
//        wrEnable_o/wrAddr_o/instBlock_o single-cycle cache write; busy_o = engine not idle.
// Config macro: ICACHE_PREFETCH_EN enables a one-entry next-line prefetch buffer.
// All outputs are registered and derived from the next state.
module icache_refill_engine
    import fabscalar_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W,
    parameter int BEAT_W  = DEF_BEAT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               miss_i,
    input  logic [ADDR_W-1:0]  missAddr_i,
    input  logic               flush_i,
    output logic               memReqValid_o,
    input  logic               memReqReady_i,
    output logic [ADDR_W-1:0]  memReqAddr_o,
    input  logic               memRespValid_i,
    input  logic [BEAT_W-1:0]  memRespData_i,
    output logic               wrEnable_o,
    output logic [ADDR_W-1:0]  wrAddr_o,
    output logic [BLOCK_W-1:0] instBlock_o,
    output logic               busy_o
);

    localparam int OFF_W = $clog2(BLOCK_W / 8);

    refillState_t       state;
    refillState_t       stateNext;
    logic               capture;
    logic [ADDR_W-1:0]  blkAddr;
    logic [ADDR_W-1:0]  missAligned;
    logic               dmdBeat;
    logic               dmdLast;
    logic [BLOCK_W-1:0] dmdBlock;

    assign missAligned = {missAddr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Beats outside FILL/DRAIN are a protocol error and never reach the assembler.
    assign dmdBeat = memRespValid_i && (state == RF_FILL || state == RF_DRAIN);

    icache_line_assembler #(
        .BLOCK_W (BLOCK_W),
        .BEAT_W  (BEAT_W)
    ) u_demandLine (
        .clk       (clk),
        .reset     (reset),
        .clear     (capture),
        .beatValid (dmdBeat),
        .beatData  (memRespData_i),
        .lastBeat  (dmdLast),
        .assembled (dmdBlock)
    );

`ifdef ICACHE_PREFETCH_EN
    localparam logic [ADDR_W-1:0] BLOCK_BYTES = ADDR_W'(BLOCK_W / 8);

    logic               pfValid;
    logic [ADDR_W-1:0]  pfAddr;
    logic               pfBeat;
    logic               pfLast;
    logic [BLOCK_W-1:0] pfBlock;
    logic               pfHit;

    assign pfBeat = memRespValid_i && (state == RF_PF_FILL);
    assign pfHit  = pfValid && (missAligned == pfAddr);

    icache_line_assembler #(
        .BLOCK_W (BLOCK_W),
        .BEAT_W  (BEAT_W)
    ) u_prefetchLine (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == RF_COOL),
        .beatValid (pfBeat),
        .beatData  (memRespData_i),
        .lastBeat  (pfLast),
        .assembled (pfBlock)
    );

    // The buffer is invalidated only when a new prefetch starts or its block is
    // consumed; flush_i deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            pfValid <= 1'b0;
            pfAddr  <= '0;
        end else if (state == RF_COOL || state == RF_PF_HIT) begin
            pfValid <= 1'b0;
        end else if (state == RF_PF_FILL && pfLast) begin
            pfValid <= 1'b1;
            pfAddr  <= blkAddr + BLOCK_BYTES;
        end
    end
`endif

    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        case (state)
            RF_IDLE: begin
                if (miss_i && !flush_i) begin
                    capture = 1'b1;
`ifdef ICACHE_PREFETCH_EN
                    stateNext = pfHit ? RF_PF_HIT : RF_REQ;
`else
                    stateNext = RF_REQ;
`endif
                end
            end
            RF_REQ: begin
                // A flush that coincides with the handshake still owes us a full
                // block of beats, so drain them rather than dropping back to idle.
                if (memReqReady_i) begin
                    stateNext = flush_i ? RF_DRAIN : RF_FILL;
                end else if (flush_i) begin
                    stateNext = RF_IDLE;
                end
            end
            RF_FILL: begin
                // A beat arriving with the flush is counted; if it was the last
                // one nothing remains to drain.
                if (flush_i) begin
                    stateNext = dmdLast ? RF_IDLE : RF_DRAIN;
                end else if (dmdLast) begin
                    stateNext = RF_WRITE;
                end
            end
            RF_DRAIN: begin
                if (dmdLast) begin
                    stateNext = RF_IDLE;
                end
            end
            RF_WRITE: begin
                stateNext = RF_COOL;
            end
            RF_COOL: begin
                // One dead cycle so the miss just serviced is not captured again.
`ifdef ICACHE_PREFETCH_EN
                stateNext = RF_PF_REQ;
`else
                stateNext = RF_IDLE;
`endif
            end
`ifdef ICACHE_PREFETCH_EN
            RF_PF_REQ: begin
                // A demand miss before the handshake abandons the prefetch; the
                // still-pending miss is picked up from IDLE next cycle.
                if (memReqReady_i) begin
                    stateNext = RF_PF_FILL;
                end else if (miss_i) begin
                    stateNext = RF_IDLE;
                end
            end
            RF_PF_FILL: begin
                if (pfLast) begin
                    stateNext = RF_IDLE;
                end
            end
            RF_PF_HIT: begin
                stateNext = RF_WRITE;
            end
`endif
            default: begin
                stateNext = RF_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RF_IDLE;
            blkAddr       <= '0;
            memReqValid_o <= 1'b0;
            memReqAddr_o  <= '0;
            wrEnable_o    <= 1'b0;
            wrAddr_o      <= '0;
            instBlock_o   <= '0;
            busy_o        <= 1'b0;
        end else begin
            state <= stateNext;
            if (capture) begin
                blkAddr      <= missAligned;
                memReqAddr_o <= missAligned;
            end
`ifdef ICACHE_PREFETCH_EN
            if (state == RF_COOL) begin
                memReqAddr_o <= blkAddr + BLOCK_BYTES;
            end
            memReqValid_o <= (stateNext == RF_REQ) || (stateNext == RF_PF_REQ);
`else
            memReqValid_o <= (stateNext == RF_REQ);
`endif
            wrEnable_o <= (stateNext == RF_WRITE);
            if (stateNext == RF_WRITE) begin
                wrAddr_o <= blkAddr;
`ifdef ICACHE_PREFETCH_EN
                instBlock_o <= (state == RF_PF_HIT) ? pfBlock : dmdBlock;
`else
                instBlock_o <= dmdBlock;
`endif
            end
            busy_o <= (stateNext != RF_IDLE);
        end
    end

endmodule
